memory_write_arbiter: RTL
=========================

// Module: memory_write_arbiter
// PURPOSE
//  Shares one memory write engine (addr/len/start -> busy/done/error) between NREQ requesters.
//  Each requester sees a private engine-like port: start pulse, busy, done/error.
//  Requests are latched, granted round-robin, issued downstream one at a time,
//  and completion is routed back to the owner. Sits between client DMA units and the write engine.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  ADDR_WIDTH  32  address width
//  LEN_WIDTH   32  transfer length width, bytes
// PORTS
//  clock       in   1                clock; all state on rising edge
//  reset       in   1                asynchronous, active-high
//  req_addr    in   NREQ*ADDR_WIDTH  per-requester address; sampled on req_start[i]
//  req_len     in   NREQ*LEN_WIDTH   per-requester length; sampled on req_start[i]
//  req_start   in   NREQ             one-cycle start pulse per requester
//  req_busy    out  NREQ             request i pending or in flight
//  req_done    out  NREQ             one-cycle completion pulse
//  req_error   out  NREQ             valid with req_done[i]; engine error
//  m_addr      out  ADDR_WIDTH       engine address
//  m_len       out  LEN_WIDTH        engine length
//  m_start     out  1                engine start pulse
//  m_busy      in   1                engine busy
//  m_done      in   1                engine completion pulse
//  m_error     in   1                engine error, valid with m_done
//  grant       out  $clog2(NREQ)     index of owning requester
//  grant_valid out  1                a request is issued/in flight
//  proto_err   out  1                sticky protocol violation flag
// BEHAVIOUR
//  Reset: all outputs 0, pending regs cleared, RR pointer 0, FSM IDLE.
//  Latching: req_start[i] at T with req_busy[i]=0 -> addr/len captured, pending[i]=1, req_busy[i]=1 at T+1.
//   req_start[i] while req_busy[i]=1 is ignored; proto_err set.
//  FSM (registered outputs):
//   IDLE:  any pending and m_busy=0 -> pick winner; grant, grant_valid, m_addr/m_len load; -> ISSUE.
//   ISSUE: m_start=1 for exactly this cycle; pending[grant] cleared; -> WAIT.
//   WAIT:  m_done=1 -> req_done[grant]=1, req_error[grant]=m_error, req_busy[grant]=0 next cycle;
//          grant_valid=0; -> IDLE.
//  Latency: req_start at T, idle engine -> m_start at T+2. m_done at D -> req_done at D+1;
//   next m_start earliest D+3.
//  m_addr/m_len stable from ISSUE until the cycle after m_done.
//  Round-robin: search starts at (last grant + 1) mod NREQ; after reset index 0 has priority.
//   Winner fixed on entry to ISSUE; later requests never pre-empt.
//  Simultaneous events: req_start[j] in the same cycle as m_done for i != j is accepted normally.
//   Owner may restart in the cycle req_done[i] is seen (req_busy[i] already 0).
//  m_done in IDLE/ISSUE: ignored, proto_err set. m_error without m_done: ignored.
//  proto_err: cleared only by reset.
//  Reset mid-transfer: everything aborts to reset values. Engine shares the same reset;
//   no done is reported for the aborted transfer.
// STRUCTURE
//  Package memory_write_arbiter_pkg: state_t enum {IDLE, ISSUE, WAIT}; width helper
//   localparams (GRANT_WIDTH = $clog2(NREQ)).
//  Sub-module rr_arbiter (NREQ): in pending vector + last-grant pointer;
//   out winner index + any; combinational.
//  Top: pending addr/len register file, FSM, completion demux.
// TESTING
//  Single: req_start[1], addr=0x1000, len=64 at T -> m_start at T+2 with 0x1000/64;
//   m_done at D -> req_done[1] at D+1, error 0.
//  Contention: req_start[0..3] same cycle -> issue order 0,1,2,3;
//   then all again -> 0,1,2,3 (pointer wraps from 3).
//  Fairness: requester 0 restarts on every req_done with 2 also pending
//   -> issue order alternates 0,2,0,2.
//  Error routing: m_done with m_error=1 while grant=2 -> req_error[2]=1, req_done[2]=1, others 0.
//  Protocol: req_start[1] while req_busy[1]=1 -> ignored, proto_err=1;
//   m_done in IDLE -> no req_done, proto_err=1.
//  Reset in WAIT with two pending -> all outputs 0 next cycle; no req_done after release.

Source files
------------

// File: rtl/memory_write_arbiter_pkg.sv
// Shared types and width helpers for the memory write arbiter.
// FSM state encoding, default parameter values, grant width.
package memory_write_arbiter_pkg;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 32;
  localparam int GRANT_WIDTH    = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic int grant_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_write_arbiter_if.sv
// Requester and engine side bundle of the memory write arbiter.
// slave: arbiter view; master: requesters + engine view.
interface memory_write_arbiter_if
  import memory_write_arbiter_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

  localparam int GW = grant_width(NREQ);

  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*LEN_WIDTH-1:0]  req_len;
  logic [NREQ-1:0]            req_start;
  logic [NREQ-1:0]            req_busy;
  logic [NREQ-1:0]            req_done;
  logic [NREQ-1:0]            req_error;

  logic [ADDR_WIDTH-1:0]      m_addr;
  logic [LEN_WIDTH-1:0]       m_len;
  logic                       m_start;
  logic                       m_busy;
  logic                       m_done;
  logic                       m_error;

  logic [GW-1:0]              grant;
  logic                       grant_valid;
  logic                       proto_err;

  modport slave (
    input  req_addr, req_len, req_start,
    input  m_busy, m_done, m_error,
    output req_busy, req_done, req_error,
    output m_addr, m_len, m_start,
    output grant, grant_valid, proto_err
  );

  modport master (
    output req_addr, req_len, req_start,
    output m_busy, m_done, m_error,
    input  req_busy, req_done, req_error,
    input  m_addr, m_len, m_start,
    input  grant, grant_valid, proto_err
  );

endinterface

// File: rtl/memory_write_arbiter_rr.sv
// Combinational round-robin picker: pending vector + last grant
// in, winner index + any out; search starts at last + 1.
module rr_arbiter
  import memory_write_arbiter_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int GW   = grant_width(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   winner,
  output logic            any
);

  // One spare bit so last + k never overflows before the wrap.
  localparam int SW = GW + 1;

  logic [SW-1:0] idx;

  // Walk from farthest to nearest; the nearest hit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, last} + SW'(k);
      if (idx >= SW'(NREQ)) begin
        idx = idx - SW'(NREQ);
      end
      if (pending[idx[GW-1:0]]) begin
        winner = idx[GW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_write_arbiter.sv
// Shares one write engine among NREQ requesters, round-robin.
// Ports: clock, reset (async high), bus (slave modport).
module memory_write_arbiter
  import memory_write_arbiter_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input logic                   clock,
  input logic                   reset,
  memory_write_arbiter_if.slave bus
);

  localparam int GW = grant_width(NREQ);

  state_t                state_q, state_d;

  logic [NREQ-1:0]       pending_q, busy_q;
  logic [NREQ-1:0]       accept, clr_pend, clr_busy;
  logic [NREQ-1:0]       grant_oh;
  logic [ADDR_WIDTH-1:0] addr_rf [NREQ];
  logic [LEN_WIDTH-1:0]  len_rf  [NREQ];

  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [GW-1:0]         winner;
  logic                  any;

  logic                  gv_q, gv_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [LEN_WIDTH-1:0]  m_len_q, m_len_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [NREQ-1:0]       err_q, err_d;

  logic                  perr_q;
  logic                  bad_done, bad_start;

  assign accept    = bus.req_start & ~busy_q;
  assign bad_start = |(bus.req_start & busy_q);
  assign grant_oh  = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .pending (pending_q),
    .last    (last_q),
    .winner  (winner),
    .any     (any)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    gv_d     = gv_q;
    m_addr_d = m_addr_q;
    m_len_d  = m_len_q;
    start_d  = 1'b0;
    done_d   = '0;
    err_d    = '0;
    clr_pend = '0;
    clr_busy = '0;
    bad_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        bad_done = bus.m_done;
        // Hold off one cycle after a completion so the
        // engine's busy settles and the owner can re-request.
        if (any && !bus.m_busy && !(|done_q)) begin
          state_d  = ISSUE;
          grant_d  = winner;
          last_d   = winner;
          gv_d     = 1'b1;
          m_addr_d = addr_rf[winner];
          m_len_d  = len_rf[winner];
          start_d  = 1'b1;
        end
      end
      ISSUE: begin
        bad_done = bus.m_done;
        clr_pend = grant_oh;
        state_d  = WAIT;
      end
      WAIT: begin
        if (bus.m_done) begin
          done_d   = grant_oh;
          err_d    = bus.m_error ? grant_oh : '0;
          clr_busy = grant_oh;
          gv_d     = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= GW'(NREQ - 1);
      gv_q     <= 1'b0;
      start_q  <= 1'b0;
      m_addr_q <= '0;
      m_len_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      gv_q     <= gv_d;
      start_q  <= start_d;
      m_addr_q <= m_addr_d;
      m_len_q  <= m_len_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      busy_q    <= '0;
      perr_q    <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        addr_rf[i] <= '0;
        len_rf[i]  <= '0;
      end
    end else begin
      pending_q <= (pending_q & ~clr_pend) | accept;
      busy_q    <= (busy_q & ~clr_busy) | accept;
      perr_q    <= perr_q | bad_start | bad_done;
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          addr_rf[i] <=
            bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          len_rf[i]  <=
            bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
      end
    end
  end

  assign bus.req_busy    = busy_q;
  assign bus.req_done    = done_q;
  assign bus.req_error   = err_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_len       = m_len_q;
  assign bus.m_start     = start_q;
  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.proto_err   = perr_q;

endmodule
